fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
- REQ-001: Parameter WIDTH, 8, data width of each requester and of the FIFO write port.
- REQ-002: Parameter N_REQ, 4, number of requesters sharing the FIFO write port (legal 2..8).
- REQ-003: Parameter MAX_BURST, 4, maximum consecutive beats one owner may write before arbitration (legal 1..16).
- REQ-004: I_CLK  input  1  single clock, all logic on rising edge.
- REQ-005: I_RESET  input  1  reset, synchronous and active-high.
- REQ-006: I_REQ  input  N_REQ  per-requester valid, held with stable data until granted.
- REQ-007: I_DIN  input  N_REQ*WIDTH  requester k data in bits [k*WIDTH +: WIDTH].
- REQ-008: O_GNT  output  N_REQ  one-hot-or-zero, combinational accept strobe; beat transfers when I_REQ[k] and O_GNT[k] are both high at a rising edge.
- REQ-009: I_FULL  input  1  FIFO full flag.
- REQ-010: I_AFULL  input  1  FIFO almost-full flag, FIFO built with A_FULL_EMPTY=2 (high when at most one slot free).
- REQ-011: O_WE  output  1  registered FIFO write enable.
- REQ-012: O_DOUT  output  WIDTH  registered FIFO write data.
- REQ-013: O_OWNER  output  clog2(N_REQ)  index of current/last burst owner.
- REQ-014: O_BUSY  output  1  high while FSM in BURST.
- REQ-015: O_BEATS  output  N_REQ*16  per-requester beat counters (see Configuration).

Function
- REQ-016: SPACE SHALL be defined as !I_FULL && !(O_WE && I_AFULL); no grant is issued when SPACE=0.
- REQ-017: A transfer from requester k in cycle t SHALL produce O_WE=1 and O_DOUT=I_DIN slice k in cycle t+1 (1-cycle latency); O_WE=0 in any cycle following no transfer.
- REQ-018: FSM states SHALL be IDLE and BURST.
- REQ-019: In IDLE, candidate SHALL be the first k with I_REQ[k]=1 searching upward from RR_PTR modulo N_REQ; O_GNT[candidate]=SPACE.
- REQ-020: IDLE -> BURST on a transfer; owner=candidate, beat count=1; if MAX_BURST=1, remain IDLE and set RR_PTR=candidate+1 mod N_REQ.
- REQ-021: In BURST, O_GNT[owner]=I_REQ[owner] && SPACE; all other grants zero.
- REQ-022: In BURST, each transfer increments beat count; the transfer bringing it to MAX_BURST returns FSM to IDLE with RR_PTR=owner+1 mod N_REQ.
- REQ-023: In BURST, I_REQ[owner]=0 SHALL return FSM to IDLE next cycle with RR_PTR=owner+1 mod N_REQ and no grant that cycle.
- REQ-024: SPACE=0 in BURST SHALL hold state, owner and beat count unchanged.
- REQ-025: Total writes issued SHALL never exceed free FIFO slots; no write is ever issued while I_FULL=1.

Reset
- REQ-026: I_RESET=1 at a rising edge SHALL force FSM=IDLE, RR_PTR=0, owner=0, beat count=0, O_WE=0, O_DOUT=0, O_BEATS=0; O_GNT SHALL be 0 while I_RESET=1.
- REQ-027: Reset mid-burst SHALL discard any in-flight write (O_WE=0 the following cycle).

Configuration
- REQ-028: Macro FIFO_WR_ARB_STATS_EN defined: O_BEATS slice k SHALL count transfers from requester k, 16-bit, saturating at 16'hFFFF.
- REQ-029: Macro undefined: O_BEATS SHALL be constant zero and no counter registers exist.

Structure
- REQ-030: Shared package fifo_pkg SHALL hold FSM state encodings and BEAT_CNT_W=16.
- REQ-031: Round-robin search SHALL be sub-module rr_pick (inputs request vector, start pointer; outputs valid, index).

Verification
- REQ-032: I_RESET=1 two cycles with I_REQ=4'b1111 -> O_GNT=0, O_WE=0, O_BEATS=0, O_BUSY=0.
- REQ-033: I_REQ=4'b1111 constant, FIFO DEPTH=10 read every cycle -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; O_DOUT matches per beat.
- REQ-034: No FIFO reads, I_REQ=4'b0011 -> exactly 10 writes accepted, then O_GNT=0 permanently, I_FULL=1, no write while full.
- REQ-035: Requester 2 drops I_REQ after 2 beats with I_REQ[3]=1 -> one idle cycle, then requester 3 granted, O_OWNER=3.
- REQ-036: I_RESET at requester 2's second beat -> next cycle O_WE=0, O_BUSY=0; after release with I_REQ=4'b0101, requester 0 granted first.
- REQ-037: With FIFO_WR_ARB_STATS_EN, 300 beats from requester 1 -> O_BEATS[31:16]=300, others 0; without macro all 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding, counter width, saturating increment.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  localparam int BEAT_CNT_W = 16;

  function automatic logic [BEAT_CNT_W-1:0] sat_inc(input logic [BEAT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request at or above start, wrapping modulo N_REQ.
// Latency: combinational. Backpressure: none, pure function of inputs.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             vld,
  output logic [IW-1:0]    idx
);

  int k;

  // Walk offsets from farthest to nearest so the nearest match wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    k   = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = int'(start) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (req[k]) begin
        vld = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst round-robin arbiter sharing one FIFO write port; optional per-requester stats (FIFO_WR_ARB_STATS_EN).
// Latency: grant combinational, O_WE/O_DOUT one cycle after the accepted beat.
// Backpressure: no grant while FIFO full, or almost full with a write still in flight.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic [N_REQ-1:0]            I_REQ,
  input  logic [N_REQ*WIDTH-1:0]      I_DIN,
  output logic [N_REQ-1:0]            O_GNT,
  input  logic                        I_FULL,
  input  logic                        I_AFULL,
  output logic                        O_WE,
  output logic [WIDTH-1:0]            O_DOUT,
  output logic [$clog2(N_REQ)-1:0]    O_OWNER,
  output logic                        O_BUSY,
  output logic [N_REQ*BEAT_CNT_W-1:0] O_BEATS
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_q;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] rr_ptr_q;
  logic [CW-1:0] beats_q;

  logic          space;
  logic          cand_vld;
  logic [IW-1:0] cand_idx;
  logic [IW-1:0] xfer_idx;
  logic          xfer;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_rr_pick (
    .req   (I_REQ),
    .start (rr_ptr_q),
    .vld   (cand_vld),
    .idx   (cand_idx)
  );

  // A write registered this cycle still lands, so almost-full must already block.
  assign space    = !I_FULL && !(O_WE && I_AFULL);
  assign xfer_idx = (state_q == ST_IDLE) ? cand_idx : owner_q;
  assign xfer     = |(O_GNT & I_REQ);

  always_comb begin
    O_GNT = '0;
    if (!I_RESET && space) begin
      if (state_q == ST_IDLE) begin
        if (cand_vld) O_GNT[cand_idx] = 1'b1;
      end else begin
        O_GNT[owner_q] = I_REQ[owner_q];
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
      O_WE     <= 1'b0;
      O_DOUT   <= '0;
    end else begin
      O_WE <= xfer;
      if (xfer) O_DOUT <= I_DIN[int'(xfer_idx)*WIDTH +: WIDTH];
      case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            owner_q <= cand_idx;
            beats_q <= CW'(1);
            if (MAX_BURST == 1) rr_ptr_q <= next_idx(cand_idx);
            else                state_q  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!I_REQ[owner_q]) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= next_idx(owner_q);
          end else if (xfer) begin
            beats_q <= beats_q + 1'b1;
            if (beats_q == CW'(MAX_BURST - 1)) begin
              state_q  <= ST_IDLE;
              rr_ptr_q <= next_idx(owner_q);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign O_OWNER = owner_q;
  assign O_BUSY  = (state_q == ST_BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q [N_REQ];

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      for (int i = 0; i < N_REQ; i++) beat_cnt_q[i] <= '0;
    end else if (xfer) begin
      beat_cnt_q[xfer_idx] <= sat_inc(beat_cnt_q[xfer_idx]);
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_beats
    assign O_BEATS[g*BEAT_CNT_W +: BEAT_CNT_W] = beat_cnt_q[g];
  end
`else
  assign O_BEATS = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: scenario tasks against a behavioural arbiter + FIFO occupancy model.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 10;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [W-1:0]  dat [N];
  logic [N*W-1:0] din_bus;
  logic          full_i, afull_i;
  logic [N-1:0]  O_GNT;
  logic          O_WE;
  logic [W-1:0]  O_DOUT;
  logic [1:0]    O_OWNER;
  logic          O_BUSY;
  logic [N*16-1:0] O_BEATS;

  logic rd_en;
  int   m_cnt;
  bit   m_busy;
  int   m_owner, m_beats, m_ptr;
  logic m_we;
  logic [W-1:0] m_dout;
  int   m_stats [N];
  logic [N-1:0] e_gnt;
  logic [N*16-1:0] e_beats;
  bit   m_xfer;
  int   m_k;
  int   grants [$];
  int   n_tests, n_fail;

  assign din_bus = {dat[3], dat[2], dat[1], dat[0]};

  fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .I_REQ   (req),
    .I_DIN   (din_bus),
    .O_GNT   (O_GNT),
    .I_FULL  (full_i),
    .I_AFULL (afull_i),
    .O_WE    (O_WE),
    .O_DOUT  (O_DOUT),
    .O_OWNER (O_OWNER),
    .O_BUSY  (O_BUSY),
    .O_BEATS (O_BEATS)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive FIFO flags, then derive the expected grant from the arbitration rules.
  task automatic settle();
    bit space;
    int s;
    full_i  = (m_cnt >= DEPTH);
    afull_i = (m_cnt >= DEPTH - 1);
    #1;
    space = !full_i && !(m_we && afull_i);
    e_gnt = '0;
    m_k   = -1;
    if (!rst && space) begin
      if (m_busy) begin
        if (req[m_owner]) m_k = m_owner;
      end else begin
        for (int i = 0; i < N; i++) begin
          s = (m_ptr + i) % N;
          if (req[s]) begin
            m_k = s;
            break;
          end
        end
      end
    end
    if (m_k >= 0) e_gnt[m_k] = 1'b1;
    m_xfer = (m_k >= 0);
`ifdef FIFO_WR_ARB_STATS_EN
    for (int i = 0; i < N; i++) e_beats[i*16 +: 16] = 16'(m_stats[i]);
`else
    e_beats = '0;
`endif
  endtask

  task automatic advance();
    bit rd_ok;
    @(posedge clk);
    rd_ok = rd_en && (m_cnt > 0);
    m_cnt = m_cnt - (rd_ok ? 1 : 0) + (m_we ? 1 : 0);
    if (m_cnt > DEPTH) m_cnt = DEPTH;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
      m_we = 1'b0; m_dout = '0;
      for (int i = 0; i < N; i++) m_stats[i] = 0;
    end else begin
      if (m_xfer) begin
        grants.push_back(m_k);
        if (m_stats[m_k] < 65535) m_stats[m_k]++;
        m_dout = dat[m_k];
      end
      m_we = m_xfer;
      if (!m_busy) begin
        if (m_xfer) begin
          m_owner = m_k;
          m_beats = 1;
          if (MB == 1) m_ptr = (m_k + 1) % N;
          else         m_busy = 1;
        end
      end else if (!req[m_owner]) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else if (m_xfer) begin
        m_beats++;
        if (m_beats == MB) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % N;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    rd_en = 1'b0;
    settle(); advance();
    settle(); advance();
    rst = 1'b0;
    m_cnt = 0;
    grants.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      settle(); advance();
    end
    settle();
    n_tests++;
    if (O_GNT !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", O_GNT); end
    n_tests++;
    if (O_WE !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", O_WE); end
    n_tests++;
    if (O_BEATS !== '0) begin n_fail++; $display("FAIL reset_beats got %h want 0", O_BEATS); end
    n_tests++;
    if (O_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", O_BUSY); end
    advance();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    rd_en = 1'b1;
    req = 4'b1111;
    for (int k = 0; k < N; k++) dat[k] = W'($urandom);
    for (int c = 0; c < 40; c++) begin
      settle();
      n_tests++;
      if (O_GNT !== e_gnt) begin n_fail++; $display("FAIL rr_gnt cyc %0d got %b want %b", c, O_GNT, e_gnt); end
      n_tests++;
      if (O_WE !== m_we || (m_we && O_DOUT !== m_dout)) begin
        n_fail++; $display("FAIL rr_write cyc %0d got we=%b d=%h want we=%b d=%h", c, O_WE, O_DOUT, m_we, m_dout);
      end
      advance();
      if (m_xfer) dat[m_k] = W'($urandom);
    end
    n_tests++;
    if (grants.size() < 20) begin
      n_fail++; $display("FAIL rr_count got %0d grants want >=20", grants.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_tests++;
        if (grants[i] != (i / 4) % 4) begin
          n_fail++; $display("FAIL rr_order beat %0d got %0d want %0d", i, grants[i], (i / 4) % 4);
        end
      end
    end
  endtask

  task automatic test_fill();
    int writes;
    do_reset();
    rd_en = 1'b0;
    req = 4'b0011;
    writes = 0;
    for (int c = 0; c < 30; c++) begin
      settle();
      if (O_WE === 1'b1) writes++;
      n_tests++;
      if (O_WE === 1'b1 && full_i) begin n_fail++; $display("FAIL fill_overflow cyc %0d got we=1 while full want 0", c); end
      n_tests++;
      if (O_GNT !== e_gnt) begin n_fail++; $display("FAIL fill_gnt cyc %0d got %b want %b", c, O_GNT, e_gnt); end
      advance();
      if (m_xfer) dat[m_k] = W'($urandom);
    end
    settle();
    n_tests++;
    if (writes != 10) begin n_fail++; $display("FAIL fill_writes got %0d want 10", writes); end
    n_tests++;
    if (O_GNT !== 4'b0000) begin n_fail++; $display("FAIL fill_final_gnt got %b want 0000", O_GNT); end
    n_tests++;
    if (m_cnt != DEPTH) begin n_fail++; $display("FAIL fill_level got %0d want %0d", m_cnt, DEPTH); end
  endtask

  task automatic test_drop();
    logic [N-1:0] gseq [4];
    logic [N-1:0] want [4];
    int b2;
    want[0] = 4'b0100; want[1] = 4'b0100; want[2] = 4'b0000; want[3] = 4'b1000;
    do_reset();
    rd_en = 1'b1;
    req = 4'b1100;
    b2 = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      gseq[c] = O_GNT;
      advance();
      if (m_xfer && m_k == 2) begin
        b2++;
        if (b2 == 2) req[2] = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (gseq[c] !== want[c]) begin n_fail++; $display("FAIL drop_gnt cyc %0d got %b want %b", c, gseq[c], want[c]); end
    end
    settle();
    n_tests++;
    if (O_OWNER !== 2'd3 || O_BUSY !== 1'b1) begin
      n_fail++; $display("FAIL drop_owner got owner=%0d busy=%b want owner=3 busy=1", O_OWNER, O_BUSY);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rd_en = 1'b1;
    req = 4'b0100;
    settle(); advance();
    rst = 1'b1;
    settle();
    n_tests++;
    if (O_GNT !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt got %b want 0000", O_GNT); end
    advance();
    rst = 1'b0;
    req = 4'b0101;
    settle();
    n_tests++;
    if (O_WE !== 1'b0 || O_BUSY !== 1'b0) begin
      n_fail++; $display("FAIL midrst_state got we=%b busy=%b want 0 0", O_WE, O_BUSY);
    end
    n_tests++;
    if (O_GNT !== 4'b0001) begin n_fail++; $display("FAIL midrst_first got %b want 0001", O_GNT); end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < N; k++) dat[k] = W'($urandom);
    for (int c = 0; c < 600; c++) begin
      rd_en = (c < 300) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
      rst   = ($urandom_range(99) == 0);
      settle();
      n_tests++;
      if (O_GNT !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc %0d got %b want %b", c, O_GNT, e_gnt); end
      n_tests++;
      if (O_WE !== m_we || (m_we && O_DOUT !== m_dout)) begin
        n_fail++; $display("FAIL rnd_write cyc %0d got we=%b d=%h want we=%b d=%h", c, O_WE, O_DOUT, m_we, m_dout);
      end
      n_tests++;
      if (O_BUSY !== logic'(m_busy) || O_OWNER !== 2'(m_owner)) begin
        n_fail++; $display("FAIL rnd_state cyc %0d got busy=%b own=%0d want busy=%b own=%0d", c, O_BUSY, O_OWNER, m_busy, m_owner);
      end
      n_tests++;
      if (O_BEATS !== e_beats) begin n_fail++; $display("FAIL rnd_beats cyc %0d got %h want %h", c, O_BEATS, e_beats); end
      n_tests++;
      if (O_WE === 1'b1 && full_i) begin n_fail++; $display("FAIL rnd_overflow cyc %0d got we=1 while full want 0", c); end
      advance();
      if (m_xfer) begin
        req[m_k] = $urandom_range(1);
        dat[m_k] = W'($urandom);
      end
      for (int k = 0; k < N; k++) begin
        if (!req[k] && $urandom_range(3) == 0) begin
          req[k] = 1'b1;
          dat[k] = W'($urandom);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_stats();
    int cnt;
    logic [N*16-1:0] want;
    do_reset();
    rd_en = 1'b1;
    req = 4'b0010;
    dat[1] = 8'h5A;
    cnt = 0;
    for (int c = 0; c < 1500 && cnt < 300; c++) begin
      settle();
      advance();
      if (m_xfer) begin
        cnt++;
        dat[1] = W'($urandom);
        if (cnt == 300) req = '0;
      end
    end
    n_tests++;
    if (cnt != 300) begin n_fail++; $display("FAIL stats_timeout got %0d beats want 300", cnt); end
    settle();
`ifdef FIFO_WR_ARB_STATS_EN
    want = {16'd0, 16'd0, 16'd300, 16'd0};
`else
    want = '0;
`endif
    n_tests++;
    if (O_BEATS !== want) begin n_fail++; $display("FAIL stats_beats got %h want %h", O_BEATS, want); end
    advance();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; req = '0; rd_en = 1'b0;
    for (int k = 0; k < N; k++) begin dat[k] = '0; m_stats[k] = 0; end
    m_cnt = 0; m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
    m_we = 1'b0; m_dout = '0; m_xfer = 0; m_k = -1;
    full_i = 1'b0; afull_i = 1'b0; e_gnt = '0; e_beats = '0;
    @(negedge clk);
    advance();
    test_reset();
    test_round_robin();
    test_fill();
    test_drop();
    test_reset_mid();
    test_random();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
